// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin grant,
// registered operands, and a response register held until the owner accepts.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_src1,
    input  logic [DATA_W-1:0] req0_src2,
    input  logic [CTRL_W-1:0] req0_ctrl,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_src1,
    input  logic [DATA_W-1:0] req1_src2,
    input  logic [CTRL_W-1:0] req1_ctrl,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic [2:0]        rsp0_flags,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic [2:0]        rsp1_flags,

    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_cout,
    input  logic              alu_overflow,

    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                owner_q, owner_d;
    logic [DATA_W-1:0]   src1_q, src1_d;
    logic [DATA_W-1:0]   src2_q, src2_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [2:0]          flags_q, flags_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            src1_q       <= '0;
            src2_q       <= '0;
            ctrl_q       <= '0;
            result_q     <= '0;
            flags_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            ctrl_q       <= ctrl_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        ctrl_d       = ctrl_q;
        result_d     = result_q;
        flags_d      = flags_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the requester not served last wins; last_grant=1 favours 0.
                if (rst_n) begin
                    req0_ready = req0_valid && (!req1_valid || last_grant_q);
                    req1_ready = req1_valid && (!req0_valid || !last_grant_q);
                end
                if (req0_ready) begin
                    src1_d  = req0_src1;
                    src2_d  = req0_src2;
                    ctrl_d  = req0_ctrl;
                    owner_d = 1'b0;
                    state_d = EXEC;
                end else if (req1_ready) begin
                    src1_d  = req1_src1;
                    src2_d  = req1_src2;
                    ctrl_d  = req1_ctrl;
                    owner_d = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_result;
                flags_d  = {alu_zero, alu_cout, alu_overflow};
                state_d  = RESP;
            end
            RESP: begin
                rsp0_valid = !owner_q;
                rsp1_valid = owner_q;
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign alu_src1    = src1_q;
    assign alu_src2    = src2_q;
    assign alu_ctrl    = ctrl_q;
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign rsp0_flags  = flags_q;
    assign rsp1_flags  = flags_q;
    assign busy        = (state_q != IDLE);
    assign owner       = owner_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 32-bit ALU between two requesters (e.g. main datapath and address/branch unit) with a valid/ready handshake on both the request and response sides. Fair round-robin grant, operands registered before issue, ALU result and flags captured into a response register held until the owner accepts it. Sits between the requesters and the ALU instance; the ALU's own rst_n ties to the same rst_n at the top level.

## Interface
- DATA_W, 32, operand/result width
- CTRL_W, 4, ALU control width (passed through uninterpreted)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&&ready
- req0_src1, req0_src2 / req1_src1, req1_src2  in  DATA_W  operands
- req0_ctrl / req1_ctrl  in  CTRL_W  ALU control code
- rsp0_valid / rsp1_valid  out  1  response available to that requester
- rsp0_ready / rsp1_ready  in  1  requester consumes response
- rsp0_result / rsp1_result  out  DATA_W  captured ALU result
- rsp0_flags / rsp1_flags  out  3  {zero, cout, overflow} captured from ALU
- alu_src1, alu_src2  out  DATA_W  to ALU
- alu_ctrl  out  CTRL_W  to ALU
- alu_result  in  DATA_W, alu_zero / alu_cout / alu_overflow  in  1  from ALU
- busy  out  1  state != IDLE
- owner  out  1  requester owning current operation (valid when busy)

## Operation
- FSM: IDLE -> EXEC -> RESP -> IDLE. One operation in flight.
- IDLE: if exactly one reqN_valid, that reqN_ready=1. If both valid, grant the one not served last (last_grant register; reset 1 so requester 0 wins first tie). ready is combinational from state, last_grant and valids; at most one ready high; ready low while rst_n=0. On handshake: latch src1/src2/ctrl into operand regs, owner<=N, -> EXEC.
- EXEC (exactly 1 cycle): alu_src1/src2/ctrl driven from operand regs; at end of cycle capture alu_result and flags into response regs, -> RESP.
- RESP: rsp<owner>_valid=1, other rsp valid=0; result/flags stable. On rsp<owner>_ready: last_grant<=owner, -> IDLE. Stays in RESP indefinitely while ready low.
- Outside EXEC, alu_src1/src2/ctrl hold operand reg values (no toggling requirement beyond EXEC).
- rspN_result/flags of the non-owner are don't-care; bench checks only when valid.
- Arbiter never alters ctrl code or data; width of all data paths exactly DATA_W, no extension.
- Requests arriving in EXEC/RESP wait (ready=0); valid may drop without handshake with no side effects.
- rsp_ready asserted with no pending response is ignored.

## Timing
- Reset (edge with rst_n=0): state IDLE, last_grant=1, owner=0, operand regs/result regs/flags=0, all rsp_valid=0, busy=0, alu_* outputs=0. Reset mid-EXEC or mid-RESP abandons the operation; no response issued.
- Handshake at edge T -> EXEC during cycle T..T+1 -> rsp_valid high from edge T+1 (visible in cycle after EXEC), i.e. 2 cycles request-accept to response-valid.
- Minimum 3 cycles per operation (IDLE, EXEC, RESP with same-cycle rsp_ready); max throughput 1 op / 3 cycles.
- Response accepted at edge T' -> IDLE in cycle after; new grant possible that cycle.

## Test plan
- Single op: req0 src1=0x0000_0005, src2=0x0000_0003, add code; -> req0_ready same cycle, rsp0_valid 2 cycles later, result=0x8, flags=3'b000, rsp1_valid never high.
- Tie after reset: both valid same cycle -> req0 granted first; with both held valid, grants alternate 0,1,0,1 over 4 ops; owner matches each response.
- Backpressure: rsp1_ready low 5 cycles -> rsp1_valid, result, flags stable 5 cycles, req0_ready stays 0 though req0_valid=1; req0 granted cycle after rsp1 handshake.
- Flags: add 0x7FFF_FFFF + 0x1 -> result 0x8000_0000, overflow=1, zero=0; sub 0x1234 - 0x1234 -> result 0, zero=1.
- Reset mid-EXEC: rst_n=0 for one edge during EXEC -> all outputs reset values next cycle, no rsp_valid ever for that op; next tie grants requester 0.
- Withdrawal: req1_valid pulses one cycle while busy, then drops -> never granted, no response to requester 1.
